// File: rtl/lab01_pkg.sv
// Shared definitions for the Lab01 tick/switch front end and the LED FSM behind it.
// Build option: DEBOUNCE_EN selects the debounce FSM in sw_debounce.
package lab01_pkg;

    localparam int unsigned DEF_CLK_HZ    = 125_000_000;
    localparam int unsigned DEF_TICK_HZ   = 1;
    localparam int unsigned DEF_PRESCALE  = DEF_CLK_HZ / DEF_TICK_HZ;
    localparam int unsigned DEF_DB_CYCLES = 1_250_000;
    localparam int unsigned SW_W          = 2;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } db_state_e;

    typedef logic [SW_W-1:0] sw_mode_t;

    // Mode codes as seen by the LED FSM
    localparam sw_mode_t MODE_TRAFFIC = 2'b00;

endpackage

// File: rtl/tick_sw_frontend_if.sv
// Switch/tick bundle between the board-facing front end and the LED FSM.
interface tick_sw_frontend_if;
    import lab01_pkg::*;

    sw_mode_t sw_raw;
    logic     tick;
    sw_mode_t sw_db;
    logic     sw_chg;

    modport master (output sw_raw, input tick, input sw_db, input sw_chg);
    modport slave  (input sw_raw, output tick, output sw_db, output sw_chg);

endinterface

// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus optional debounce FSM for a WIDTH-bit switch word.
// Build option: DEBOUNCE_EN (undefined = synchronise only, no stability window).
module sw_debounce
    import lab01_pkg::*;
#(
    parameter int unsigned WIDTH     = SW_W,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic             sw_chg,
    output logic             upd_c
);

    if (DB_CYCLES < 1) begin : g_bad_db
        $error("sw_debounce: DB_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    // Metastability guard; only s2 is consumed downstream
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw_raw;
            s2 <= s1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    db_state_e        state_q, state_d;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [WIDTH-1:0] db_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            sw_db   <= '0;
            sw_chg  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            sw_db   <= db_d;
            sw_chg  <= upd_c;
        end
    end

    // Candidate must be seen DB_CYCLES+1 times in a row before it is accepted
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        db_d    = sw_db;
        upd_c   = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2 != sw_db) begin
                    state_d = PENDING;
                    cand_d  = s2;
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                if (s2 == sw_db) begin
                    state_d = STABLE;
                end else if (s2 != cand_q) begin
                    cand_d = s2;
                    cnt_d  = '0;
                end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
                    db_d    = cand_q;
                    upd_c   = 1'b1;
                    state_d = STABLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = STABLE;
        endcase
    end
`else
    assign upd_c = (s2 != sw_db);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_db  <= '0;
            sw_chg <= 1'b0;
        end else begin
            sw_db  <= s2;
            sw_chg <= upd_c;
        end
    end
`endif

endmodule

// File: rtl/tick_sw_frontend.sv
// Lab01 front end: prescaled FSM step tick plus cleaned-up slide switch mode bits.
// Build option: DEBOUNCE_EN enables the switch debounce window.
module tick_sw_frontend
    import lab01_pkg::*;
#(
    parameter int unsigned CLK_HZ    = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ   = DEF_TICK_HZ,
    parameter int unsigned DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    tick_sw_frontend_if.slave  bus
);

    localparam int unsigned PRESCALE = CLK_HZ / TICK_HZ;
    localparam int unsigned PCW      = $clog2(PRESCALE);

    if (PRESCALE < 2) begin : g_bad_prescale
        $error("tick_sw_frontend: CLK_HZ/TICK_HZ must be >= 2");
    end

    logic           upd_c;
    logic [PCW-1:0] pre_cnt;
    logic           tick_q;

    sw_debounce #(
        .WIDTH     (SW_W),
        .DB_CYCLES (DB_CYCLES)
    ) u_sw_debounce (
        .clk    (clk),
        .rst    (rst),
        .sw_raw (bus.sw_raw),
        .sw_db  (bus.sw_db),
        .sw_chg (bus.sw_chg),
        .upd_c  (upd_c)
    );

    // A mode change restarts the period and swallows a tick landing on the same edge
    always_ff @(posedge clk) begin
        if (!rst) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else if (upd_c) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
        end else begin
            tick_q  <= (pre_cnt == PCW'(PRESCALE - 1));
            pre_cnt <= (pre_cnt == PCW'(PRESCALE - 1)) ? '0 : pre_cnt + PCW'(1);
        end
    end

    assign bus.tick = tick_q;

endmodule

// File: tb/tb_tick_sw_frontend.sv
// Bench for tick_sw_frontend: vector table, corner sequences and a random run against a window-based model.
module tb_tick_sw_frontend;

    localparam int unsigned CLK_HZ    = 20;
    localparam int unsigned TICK_HZ   = 1;
    localparam int unsigned PRESCALE  = CLK_HZ / TICK_HZ;
    localparam int unsigned DB_CYCLES = 4;
`ifdef DEBOUNCE_EN
    localparam bit DB_EN = 1'b1;
`else
    localparam bit DB_EN = 1'b0;
`endif
    // Edges from first sample of a new raw value to sw_db update
    localparam int LAT = DB_EN ? int'(DB_CYCLES) + 2 : 2;

    logic clk = 1'b0;
    logic rst;
    tick_sw_frontend_if bus_if ();

    tick_sw_frontend #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .DB_CYCLES (DB_CYCLES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: sw_db follows a value once it has been observed for DB_CYCLES+1 edges in a row
    logic [1:0] dly[$];
    logic [1:0] prev_obs;
    int         run;
    int         since;
    logic [1:0] m_db;
    logic       m_chg;
    logic       m_tick;

    task automatic model_step(input logic r, input logic [1:0] raw);
        logic [1:0] obs;
        logic       upd;
        if (!r) begin
            dly = '{2'b00, 2'b00};
            prev_obs = 2'b00;
            run    = 0;
            since  = 0;
            m_db   = 2'b00;
            m_chg  = 1'b0;
            m_tick = 1'b0;
        end else begin
            obs = dly.pop_front();
            dly.push_back(raw);
            run = (obs == prev_obs) ? run + 1 : 1;
            prev_obs = obs;
            if (DB_EN) upd = (obs != m_db) && (run >= int'(DB_CYCLES) + 1);
            else       upd = (obs != m_db);
            if (upd) m_db = obs;
            m_chg = upd;
            if (upd) begin
                since  = 0;
                m_tick = 1'b0;
            end else begin
                since++;
                m_tick = (since % int'(PRESCALE)) == 0;
            end
        end
    endtask

    // Drive at negedge, let one posedge pass, sample at the following negedge
    task automatic cycle(input logic r, input logic [1:0] raw);
        rst = r;
        bus_if.sw_raw = raw;
        @(posedge clk);
        model_step(r, raw);
        @(negedge clk);
        chk("model_tick",   8'(bus_if.tick),   8'(m_tick));
        chk("model_sw_db",  8'(bus_if.sw_db),  8'(m_db));
        chk("model_sw_chg", 8'(bus_if.sw_chg), 8'(m_chg));
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] raw;
        logic       tick;
        logic [1:0] db_deb;
        logic       chg_deb;
        logic [1:0] db_raw;
        logic       chg_raw;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0] rv;
        int         hold;

        vecs[0]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[4]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
        vecs[5]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b1};
        vecs[6]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        vecs[7]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 2'b00, 1'b0, 2'b01, 1'b0};
        vecs[9]  = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b1, 2'b01, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 1'b0, 2'b01, 1'b0, 2'b01, 1'b0};

        rst = 1'b0;
        bus_if.sw_raw = 2'b00;
        dly = '{2'b00, 2'b00};
        prev_obs = 2'b00;
        run = 0; since = 0; m_db = 2'b00; m_chg = 1'b0; m_tick = 1'b0;

        // Reset, release, clean 00->01 change
        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst, vecs[i].raw);
            chk($sformatf("vec%0d_tick", i),   8'(bus_if.tick),   8'(vecs[i].tick));
            chk($sformatf("vec%0d_sw_db", i),  8'(bus_if.sw_db),  8'(DB_EN ? vecs[i].db_deb : vecs[i].db_raw));
            chk($sformatf("vec%0d_sw_chg", i), 8'(bus_if.sw_chg), 8'(DB_EN ? vecs[i].chg_deb : vecs[i].chg_raw));
        end

        // Collision: mode change lands on the edge a tick is due
        for (int i = 0; i < 12; i++) cycle(1'b1, 2'b01);
        for (int j = 0; j <= LAT + 20; j++) begin
            cycle(1'b1, 2'b00);
            chk($sformatf("coll%0d_tick", j),   8'(bus_if.tick),   8'(j == LAT + 20));
            chk($sformatf("coll%0d_sw_chg", j), 8'(bus_if.sw_chg), 8'(j == LAT));
            chk($sformatf("coll%0d_sw_db", j),  8'(bus_if.sw_db),  8'((j >= LAT) ? 2'b00 : 2'b01));
        end

`ifdef DEBOUNCE_EN
        // Glitch of two cycles is rejected
        for (int j = 0; j < 12; j++) begin
            cycle(1'b1, (j < 2) ? 2'b10 : 2'b00);
            chk($sformatf("glitch%0d_sw_db", j),  8'(bus_if.sw_db),  8'(2'b00));
            chk($sformatf("glitch%0d_sw_chg", j), 8'(bus_if.sw_chg), 8'(1'b0));
        end
        // Reset while a change is pending aborts it
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, 2'b01);
            chk($sformatf("midrst%0d_sw_db", j), 8'(bus_if.sw_db), 8'(2'b00));
        end
        cycle(1'b0, 2'b00);
        cycle(1'b0, 2'b00);
        for (int k = 1; k <= 21; k++) begin
            cycle(1'b1, 2'b00);
            chk($sformatf("rel%0d_tick", k),   8'(bus_if.tick),   8'(k == 20));
            chk($sformatf("rel%0d_sw_db", k),  8'(bus_if.sw_db),  8'(2'b00));
            chk($sformatf("rel%0d_sw_chg", k), 8'(bus_if.sw_chg), 8'(1'b0));
        end
`else
        // Without debounce a one-cycle pulse passes straight through
        for (int j = 0; j < 5; j++) begin
            cycle(1'b1, (j == 0) ? 2'b11 : 2'b00);
            chk($sformatf("pass%0d_sw_db", j),  8'(bus_if.sw_db),  8'((j == 2) ? 2'b11 : 2'b00));
            chk($sformatf("pass%0d_sw_chg", j), 8'(bus_if.sw_chg), 8'((j == 2) || (j == 3)));
        end
`endif

        // Random switch activity with occasional resets
        for (int n = 0; n < 400; n++) begin
            rv   = 2'($urandom_range(0, 3));
            hold = int'($urandom_range(1, 9));
            if ($urandom_range(0, 40) == 0) begin
                for (int h = 0; h < hold % 3 + 1; h++) cycle(1'b0, rv);
            end else begin
                for (int h = 0; h < hold; h++) cycle(1'b1, rv);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
